// File: rtl/spram_arbiter_if.sv
// spram_arbiter_if: bundles every requester's request/response channel and the RAM port.
// slave  - the arbiter's view.
// master - the view of the surrounding requesters and RAM instance.
interface spram_arbiter_if #(
    parameter int unsigned NUM_REQ  = 2,
    parameter int unsigned DEPTH_L2 = 4,
    parameter int unsigned WIDTH    = 32
);
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ-1:0]          req_ready;
    logic [NUM_REQ-1:0]          req_we;
    logic [NUM_REQ*DEPTH_L2-1:0] req_addr;
    logic [NUM_REQ*WIDTH-1:0]    req_wdata;
    logic [NUM_REQ-1:0]          rsp_valid;
    logic [WIDTH-1:0]            rsp_data;
    logic                        ram_wr_valid;
    logic [DEPTH_L2-1:0]         ram_wr_addr;
    logic [WIDTH-1:0]            ram_wr_data;
    logic                        ram_rd_valid;
    logic [DEPTH_L2-1:0]         ram_rd_addr;
    logic                        ram_rd_ready;
    logic [WIDTH-1:0]            ram_rd_data;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, ram_rd_ready, ram_rd_data,
        output req_ready, rsp_valid, rsp_data,
        output ram_wr_valid, ram_wr_addr, ram_wr_data, ram_rd_valid, ram_rd_addr
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, ram_rd_ready, ram_rd_data,
        input  req_ready, rsp_valid, rsp_data,
        input  ram_wr_valid, ram_wr_addr, ram_wr_data, ram_rd_valid, ram_rd_addr
    );
endinterface

// File: rtl/spram_arbiter.sv
// spram_arbiter: shares one single-port RAM (1-cycle registered read) between NUM_REQ
// requesters. One grant per cycle; read responses are tagged with the winner's index and
// routed back one cycle later.
// Build option SPRAM_ARB_FIXED_PRIO_EN: fixed priority (lowest index wins, no rr_ptr);
// otherwise round-robin starting at rr_ptr.
module spram_arbiter #(
    parameter int unsigned NUM_REQ  = 2,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH_L2 = $clog2(DEPTH),
    parameter int unsigned REQ_L2   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic           clk,
    input  logic           rst,
    spram_arbiter_if.slave bus
);

    logic                gnt_vld;
    logic [REQ_L2-1:0]   gnt_idx;
    logic                gnt_we;
    logic [DEPTH_L2-1:0] gnt_addr;
    logic [WIDTH-1:0]    gnt_wdata;
    logic                xfer;
    logic                pend_vld;
    logic [REQ_L2-1:0]   pend_tag;
`ifndef SPRAM_ARB_FIXED_PRIO_EN
    logic [REQ_L2-1:0]   rr_ptr;
`endif

    // Winner selection: smallest distance from the priority origin among valid requests.
    always_comb begin
        int unsigned off;
        int unsigned best_off;
        gnt_vld   = 1'b0;
        gnt_idx   = '0;
        gnt_we    = 1'b0;
        gnt_addr  = '0;
        gnt_wdata = '0;
        off       = 0;
        best_off  = NUM_REQ;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
`ifdef SPRAM_ARB_FIXED_PRIO_EN
            off = i;
`else
            off = (i + NUM_REQ - 32'(rr_ptr)) % NUM_REQ;
`endif
            if (bus.req_valid[i] && (off < best_off)) begin
                best_off = off;
                gnt_vld  = 1'b1;
                gnt_idx  = REQ_L2'(i);
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == REQ_L2'(i)) begin
                gnt_we    = bus.req_we[i];
                gnt_addr  = bus.req_addr[i*DEPTH_L2 +: DEPTH_L2];
                gnt_wdata = bus.req_wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    assign xfer = gnt_vld && !rst;

    // Handshake, RAM drive and tagged response routing.
    always_comb begin
        bus.req_ready    = '0;
        bus.rsp_valid    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            bus.req_ready[i] = xfer && (gnt_idx == REQ_L2'(i));
            bus.rsp_valid[i] = !rst && bus.ram_rd_ready && pend_vld && (pend_tag == REQ_L2'(i));
        end
        bus.ram_wr_valid = xfer && gnt_we;
        bus.ram_wr_addr  = (xfer && gnt_we) ? gnt_addr : '0;
        bus.ram_wr_data  = (xfer && gnt_we) ? gnt_wdata : '0;
        bus.ram_rd_valid = xfer && !gnt_we;
        bus.ram_rd_addr  = (xfer && !gnt_we) ? gnt_addr : '0;
        bus.rsp_data     = rst ? '0 : bus.ram_rd_data;
    end

    // Remember which requester owns the read data the RAM returns next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_vld <= 1'b0;
            pend_tag <= '0;
        end else begin
            pend_vld <= xfer && !gnt_we;
            if (xfer && !gnt_we) begin
                pend_tag <= gnt_idx;
            end
        end
    end

`ifndef SPRAM_ARB_FIXED_PRIO_EN
    // Priority origin moves just past the last winner.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (xfer) begin
            rr_ptr <= (gnt_idx == REQ_L2'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_spram_arbiter.sv
// tb_spram_arbiter: randomized + directed bench with a reference model of the grant rule and
// memory contents; expected read responses are queued and checked by a separate monitor.
module tb_spram_arbiter;
    localparam int unsigned NR    = 3;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned W     = 32;
    localparam int unsigned AW    = $clog2(DEPTH);

    typedef struct {
        int           tag;
        logic [W-1:0] data;
        int           due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int          cyc = 0;

    // Requester drive state (held until accepted).
    bit            v  [NR];
    bit            we [NR];
    logic [AW-1:0] a  [NR];
    logic [W-1:0]  d  [NR];
    bit            drv_rst = 1'b1;

    // Reference model state.
    logic [W-1:0] ref_mem [DEPTH];
    int           ref_ptr = 0;
    exp_t         sb [$];

    spram_arbiter_if #(.NUM_REQ(NR), .DEPTH_L2(AW), .WIDTH(W)) bus ();

    spram_arbiter #(.NUM_REQ(NR), .DEPTH(DEPTH), .WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single-port RAM with a registered read.
    logic [W-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (bus.ram_wr_valid) ram[bus.ram_wr_addr] <= bus.ram_wr_data;
        bus.ram_rd_ready <= bus.ram_rd_valid;
        bus.ram_rd_data  <= ram[bus.ram_rd_addr];
    end

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Apply one cycle of stimulus, then check grant/RAM drive against the model.
    task automatic step();
        int            win;
        logic [NR-1:0] exp_ready;
        bit            exp_wr;
        bit            exp_rd;
        exp_t          e;
        @(negedge clk);
        rst = drv_rst;
        for (int i = 0; i < NR; i++) begin
            bus.req_valid[i]             = v[i];
            bus.req_we[i]                = we[i];
            bus.req_addr[i*AW +: AW]     = a[i];
            bus.req_wdata[i*W +: W]      = d[i];
        end
        #1;
        win = -1;
        if (!rst) begin
`ifdef SPRAM_ARB_FIXED_PRIO_EN
            for (int i = NR - 1; i >= 0; i--) if (v[i]) win = i;
`else
            for (int k = NR - 1; k >= 0; k--) if (v[(ref_ptr + k) % NR]) win = (ref_ptr + k) % NR;
`endif
        end
        exp_ready = '0;
        exp_wr    = 1'b0;
        exp_rd    = 1'b0;
        if (win >= 0) begin
            exp_ready = NR'(1) << win;
            exp_wr    = we[win];
            exp_rd    = !we[win];
        end
        cmp("req_ready", 64'(bus.req_ready), 64'(exp_ready));
        cmp("ram_wr_valid", 64'(bus.ram_wr_valid), 64'(exp_wr));
        cmp("ram_rd_valid", 64'(bus.ram_rd_valid), 64'(exp_rd));
        if (exp_wr) begin
            cmp("ram_wr_addr", 64'(bus.ram_wr_addr), 64'(a[win]));
            cmp("ram_wr_data", 64'(bus.ram_wr_data), 64'(d[win]));
        end
        if (exp_rd) cmp("ram_rd_addr", 64'(bus.ram_rd_addr), 64'(a[win]));
        // A response due during reset is lost.
        if (rst && sb.size() > 0 && sb[0].due == cyc) void'(sb.pop_front());
        if (rst) begin
            ref_ptr = 0;
        end else if (win >= 0) begin
            if (we[win]) begin
                ref_mem[a[win]] = d[win];
            end else begin
                e.tag  = win;
                e.data = ref_mem[a[win]];
                e.due  = cyc + 1;
                sb.push_back(e);
            end
            ref_ptr = (win + 1) % NR;
        end
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NR; i++) v[i] = 1'b0;
    endtask

    task automatic set_req(input int i, input bit w, input int addr, input logic [W-1:0] data);
        v[i]  = 1'b1;
        we[i] = w;
        a[i]  = AW'(addr);
        d[i]  = data;
    endtask

    // Response monitor: every cycle, rsp_valid must match the queued expectation.
    initial begin
        exp_t          e;
        logic [NR-1:0] exp_v;
        forever begin
            @(negedge clk);
            #2;
            exp_v = '0;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e     = sb.pop_front();
                exp_v = NR'(1) << e.tag;
                cmp("rsp_valid", 64'(bus.rsp_valid), 64'(exp_v));
                cmp("rsp_data", 64'(bus.rsp_data), 64'(e.data));
            end else begin
                cmp("rsp_valid", 64'(bus.rsp_valid), 64'(exp_v));
            end
        end
    end

    initial begin
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, i, W'($urandom));

        // Reset held with every requester asking.
        drv_rst = 1'b1;
        repeat (3) step();
        drv_rst = 1'b0;

        // Fill the RAM so later reads have known contents.
        for (int i = 0; i < int'(DEPTH); i++) begin
            clear_reqs();
            set_req(i % NR, 1'b1, i, W'($urandom));
            step();
        end
        clear_reqs();

        // Write then read back on requester 0.
        set_req(0, 1'b1, 5, 32'hDEADBEEF);
        step();
        set_req(0, 1'b0, 5, '0);
        step();
        clear_reqs();
        step();
        cmp("wr_rd_rsp_valid", 64'(bus.rsp_valid), 64'(3'b001));
        cmp("wr_rd_rsp_data", 64'(bus.rsp_data), 64'(32'hDEADBEEF));

        // Contention between two readers.
        set_req(0, 1'b1, 1, 32'h11);
        step();
        clear_reqs();
        set_req(1, 1'b1, 2, 32'h22);
        step();
        set_req(0, 1'b0, 1, '0);
        set_req(1, 1'b0, 2, '0);
        repeat (6) step();
        clear_reqs();

        // Wrap: req2 then req0.
        set_req(2, 1'b0, 3, '0);
        set_req(0, 1'b0, 4, '0);
        step();
        v[2] = 1'b0;
        step();
        clear_reqs();

        // Reset right after a read is accepted.
        set_req(1, 1'b0, 2, '0);
        step();
        clear_reqs();
        drv_rst = 1'b1;
        step();
        drv_rst = 1'b0;
        set_req(0, 1'b0, 1, '0);
        set_req(1, 1'b0, 2, '0);
        repeat (2) step();
        clear_reqs();

        // Two persistent readers, then only req1.
        set_req(0, 1'b0, 1, '0);
        set_req(1, 1'b0, 2, '0);
        repeat (4) step();
        v[0] = 1'b0;
        step();
        clear_reqs();

        // Randomized traffic honouring the hold-until-ready contract.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NR; i++) begin
                if (!v[i] && $urandom_range(0, 1) == 1) begin
                    set_req(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
                            W'($urandom));
                end
            end
            drv_rst = ($urandom_range(0, 63) == 0);
            step();
            for (int i = 0; i < NR; i++) if (((bus.req_ready >> i) & 1) != 0) v[i] = 1'b0;
        end
        drv_rst = 1'b0;
        clear_reqs();
        repeat (3) step();
        cmp("scoreboard_drained", 64'(sb.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
